dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Shares the single data-memory port between the load path (speculative loads from the load/store queue) and the committed-store buffer. It arbitrates requests, issues one transaction at a time, and returns load data tagged with ROB id. Loads in flight are squashed on branch mispredict. Committed stores always complete. It sits between the LSQ/store buffer and the dmem interface, replacing ad-hoc port sharing.

## Interface
- ROB_ID_W, default ROB_ID_SIZE: width of ROB tag.
- STARVE_LIMIT, default 4: maximum consecutive load grants while a store is waiting.

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- branch_mispredict  in  1  flush speculative load state
- ld_req  in  1  load request valid; ld_addr in 32; ld_rmask in 4 (non-zero); ld_rob_id in ROB_ID_W
- ld_ready  out  1  load accepted this cycle
- st_req  in  1  committed store valid; st_addr in 32; st_wmask in 4 (non-zero); st_wdata in 32
- st_ready  out  1  store accepted this cycle
- dmem_addr out 32; dmem_rmask out 4; dmem_wmask out 4; dmem_wdata out 32: memory request
- dmem_rdata  in  32; dmem_resp  in  1: memory response
- ld_resp_valid out 1; ld_resp_rob_id out ROB_ID_W; ld_resp_rdata out 32: raw word, one-cycle pulse
- st_done  out  1  one-cycle pulse when a store response returns
- busy  out  1  state != IDLE

## Operation
- States:
  - IDLE: no transaction outstanding.
  - LOAD_WAIT: a load is outstanding.
  - STORE_WAIT: a store is outstanding.
  - LOAD_DRAIN: a flushed load is outstanding; its response is discarded.
- IDLE grant policy (combinational):
  - A load is eligible only when ld_req && !branch_mispredict.
  - Store wins if st_req && (!eligible load || streak == STARVE_LIMIT).
  - Otherwise an eligible load wins.
- Issue on grant:
  - dmem_* are driven combinationally from the winner in the grant cycle only.
  - The unused mask is 0.
  - ld_ready or st_ready pulses in the same cycle.
- Latched on grant: the ROB id (for loads only).
- Streak counter:
  - Saturates at STARVE_LIMIT.
  - Increments on a load grant while st_req is high.
  - Clears on a store grant or whenever st_req is low.
- Transitions:
  - LOAD_WAIT:
    - dmem_resp && !branch_mispredict: ld_resp_valid=1 with latched id and dmem_rdata, then IDLE.
    - branch_mispredict && !dmem_resp: LOAD_DRAIN.
    - branch_mispredict && dmem_resp: discard the response, then IDLE.
  - LOAD_DRAIN: on dmem_resp, no ld_resp_valid, then IDLE.
  - STORE_WAIT: on dmem_resp, st_done=1, then IDLE. branch_mispredict is ignored.
- All dmem_* masks are 0 outside the grant cycle. No new grant occurs in any non-IDLE state.

## Timing
- Reset (async) values:
  - State IDLE, streak 0.
  - All masks 0; dmem_addr/wdata 0.
  - ld_ready, st_ready, ld_resp_valid, st_done, busy all 0.
- Reset mid-transaction: returns to IDLE immediately. A later stray dmem_resp in IDLE is ignored.
- Minimum latency: grant cycle N, response at earliest N+1, ld_resp_valid in the same cycle as dmem_resp. The next grant is at earliest N+2.
- dmem_resp is never expected in the grant cycle; if it is asserted in IDLE, it is ignored.
- Requesters hold req and payload stable until ready.

## Structure
- Shared package rv32i_types holds:
  - dmem_arb_state_t enum (IDLE, LOAD_WAIT, STORE_WAIT, LOAD_DRAIN).
  - ld_req_t / st_req_t structs bundling the payload fields.
- Single flat module; no sub-module. The streak counter is a few lines inside it.

## Test plan
- Load only: ld_req addr 0x1000, rmask 0xF, rob_id 5; resp 3 cycles later with rdata 0xDEADBEEF -> ld_resp_valid one cycle, rob_id 5, rdata 0xDEADBEEF; busy for 3 cycles.
- Contention: ld_req and st_req held high continuously, STARVE_LIMIT=4 -> grant order L,L,L,L,S,L,L,L,L,S. st_done pulses once per store.
- Flush in LOAD_WAIT: branch_mispredict 1 cycle before dmem_resp -> LOAD_DRAIN, no ld_resp_valid, IDLE after resp; a subsequent store is granted next cycle.
- Flush coincident with dmem_resp, and flush during STORE_WAIT: load data is dropped; the store still produces st_done.
- Flush in IDLE with ld_req and st_req both high: store granted, ld_ready=0.
- Async reset asserted in STORE_WAIT: outputs zero within the same cycle; a later dmem_resp produces no st_done.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the data-memory port arbiter: FSM state encoding,
// request payload bundles and the default ROB tag width.
package rv32i_types;

    localparam int ROB_ID_SIZE = 5;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        LOAD_WAIT  = 2'd1,
        STORE_WAIT = 2'd2,
        LOAD_DRAIN = 2'd3
    } dmem_arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  rmask;
    } ld_req_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } st_req_t;

endpackage

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between speculative loads and committed
// stores. One transaction is outstanding at a time; loads are tagged with
// their ROB id and may be squashed by a branch mispredict, stores always
// complete. A streak counter bounds how long a waiting store can be starved.
module dmem_port_arbiter
    import rv32i_types::*;
#(
    parameter int ROB_ID_W     = ROB_ID_SIZE,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                branch_mispredict,
    input  logic                ld_req,
    input  logic [31:0]         ld_addr,
    input  logic [3:0]          ld_rmask,
    input  logic [ROB_ID_W-1:0] ld_rob_id,
    output logic                ld_ready,
    input  logic                st_req,
    input  logic [31:0]         st_addr,
    input  logic [3:0]          st_wmask,
    input  logic [31:0]         st_wdata,
    output logic                st_ready,
    output logic [31:0]         dmem_addr,
    output logic [3:0]          dmem_rmask,
    output logic [3:0]          dmem_wmask,
    output logic [31:0]         dmem_wdata,
    input  logic [31:0]         dmem_rdata,
    input  logic                dmem_resp,
    output logic                ld_resp_valid,
    output logic [ROB_ID_W-1:0] ld_resp_rob_id,
    output logic [31:0]         ld_resp_rdata,
    output logic                st_done,
    output logic                busy
);

    localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

    dmem_arb_state_t     state_r;
    dmem_arb_state_t     state_nxt_s;
    logic [STREAK_W-1:0] streak_r;
    logic [ROB_ID_W-1:0] rob_id_r;
    ld_req_t             ld_pl_s;
    st_req_t             st_pl_s;
    logic                ld_eligible_s;
    logic                ld_grant_s;
    logic                st_grant_s;

    // Bundle the requester payloads.
    always_comb begin
        ld_pl_s.addr  = ld_addr;
        ld_pl_s.rmask = ld_rmask;
        st_pl_s.addr  = st_addr;
        st_pl_s.wmask = st_wmask;
        st_pl_s.wdata = st_wdata;
    end

    // Grant decision in IDLE; a squashed load is never eligible and the
    // store is forced through once the load streak reaches its limit.
    always_comb begin
        ld_eligible_s = ld_req && !branch_mispredict;
        ld_grant_s    = 1'b0;
        st_grant_s    = 1'b0;
        if (!rst && (state_r == IDLE)) begin
            if (st_req && (!ld_eligible_s || (streak_r == STREAK_MAX))) begin
                st_grant_s = 1'b1;
            end else if (ld_eligible_s) begin
                ld_grant_s = 1'b1;
            end else begin
                ld_grant_s = 1'b0;
                st_grant_s = 1'b0;
            end
        end else begin
            ld_grant_s = 1'b0;
            st_grant_s = 1'b0;
        end
    end

    // Next state and all combinational request/response outputs.
    always_comb begin
        state_nxt_s    = state_r;
        ld_ready       = 1'b0;
        st_ready       = 1'b0;
        dmem_addr      = 32'h0000_0000;
        dmem_rmask     = 4'h0;
        dmem_wmask     = 4'h0;
        dmem_wdata     = 32'h0000_0000;
        ld_resp_valid  = 1'b0;
        ld_resp_rob_id = '0;
        ld_resp_rdata  = 32'h0000_0000;
        st_done        = 1'b0;
        case (state_r)
            IDLE: begin
                if (st_grant_s) begin
                    state_nxt_s = STORE_WAIT;
                    st_ready    = 1'b1;
                    dmem_addr   = st_pl_s.addr;
                    dmem_wmask  = st_pl_s.wmask;
                    dmem_wdata  = st_pl_s.wdata;
                end else if (ld_grant_s) begin
                    state_nxt_s = LOAD_WAIT;
                    ld_ready    = 1'b1;
                    dmem_addr   = ld_pl_s.addr;
                    dmem_rmask  = ld_pl_s.rmask;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD_WAIT: begin
                if (dmem_resp && !branch_mispredict) begin
                    state_nxt_s    = IDLE;
                    ld_resp_valid  = 1'b1;
                    ld_resp_rob_id = rob_id_r;
                    ld_resp_rdata  = dmem_rdata;
                end else if (dmem_resp) begin
                    state_nxt_s = IDLE;
                end else if (branch_mispredict) begin
                    state_nxt_s = LOAD_DRAIN;
                end else begin
                    state_nxt_s = LOAD_WAIT;
                end
            end
            STORE_WAIT: begin
                if (dmem_resp) begin
                    state_nxt_s = IDLE;
                    st_done     = 1'b1;
                end else begin
                    state_nxt_s = STORE_WAIT;
                end
            end
            LOAD_DRAIN: begin
                if (dmem_resp) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = LOAD_DRAIN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    assign busy = (state_r != IDLE);

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Consecutive-load streak seen by a waiting store, saturating.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_r <= '0;
        end else if (!st_req || st_grant_s) begin
            streak_r <= '0;
        end else if (ld_grant_s && (streak_r != STREAK_MAX)) begin
            streak_r <= streak_r + STREAK_W'(1);
        end else begin
            streak_r <= streak_r;
        end
    end

    // ROB id of the outstanding load, captured on grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rob_id_r <= '0;
        end else if (ld_grant_s) begin
            rob_id_r <= ld_rob_id;
        end else begin
            rob_id_r <= rob_id_r;
        end
    end

endmodule
